// File: rtl/coord_scan_gen_if.sv
// Pixel output stream of the coordinate scan generator.
// Master drives the pixel word, slave drives out_ready.
interface coord_scan_gen_if #(
    parameter int N   = 32,
    parameter int PXW = 16
);
    logic           out_valid;
    logic           out_ready;
    logic [N-1:0]   out_re;
    logic [N-1:0]   out_im;
    logic [PXW-1:0] out_px;
    logic [PXW-1:0] out_py;
    logic           out_eol;
    logic           out_last;

    modport master (
        output out_valid, out_re, out_im,
        output out_px, out_py, out_eol, out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_re, out_im,
        input  out_px, out_py, out_eol, out_last,
        output out_ready
    );
endinterface

// File: rtl/coord_scan_gen.sv
// Raster scan of complex-plane coordinates on a power-of-two grid.
// Coordinates advance by add/subtract of the latched step; no multiplier.
module coord_scan_gen #(
    parameter int Q         = 21,
    parameter int N         = 32,
    parameter int PXW       = 16,
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int ZW        = 2,
    parameter int GRID_BASE = 8,
    parameter int ZOOM_STEP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  start_re,
    input  logic [N-1:0]  start_im,
    input  logic [ZW-1:0] zoom_level,
    coord_scan_gen_if.master ob,
    output logic          busy,
    output logic          frame_done
);

    if (Q < GRID_BASE + ((2 ** ZW) - 1) * ZOOM_STEP) begin : g_bad_q
        $error("coord_scan_gen: Q too small for deepest zoom level");
    end

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN
    } state_t;

    localparam int             SH0 = Q - GRID_BASE;
    localparam logic [PXW-1:0] XL  = PXW'(H_RES - 1);
    localparam logic [PXW-1:0] YL  = PXW'(V_RES - 1);
    localparam logic           ONE_COL = (H_RES == 1);
    localparam logic           ONE_ROW = (V_RES == 1);

    state_t         state_q;
    logic           valid_q;
    logic           busy_q;
    logic           done_q;
    logic           eol_q;
    logic           last_q;
    logic [N-1:0]   re_q;
    logic [N-1:0]   im_q;
    logic [PXW-1:0] px_q;
    logic [PXW-1:0] py_q;
    logic [N-1:0]   re0_q;
    logic [N-1:0]   im0_q;
    logic [N-1:0]   step_q;

    logic [N-1:0]   step_d;
    logic [PXW-1:0] px_d;
    logic [PXW-1:0] py_d;
    int             sh;

    always_comb begin
        sh     = SH0 - int'(zoom_level) * ZOOM_STEP;
        step_d = N'(1) << sh;
        px_d   = px_q + 1'b1;
        py_d   = py_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            eol_q   <= 1'b0;
            last_q  <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            px_q    <= '0;
            py_q    <= '0;
            re0_q   <= '0;
            im0_q   <= '0;
            step_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        re0_q   <= start_re;
                        im0_q   <= start_im;
                        step_q  <= step_d;
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        re_q    <= re0_q;
                        im_q    <= im0_q;
                        px_q    <= '0;
                        py_q    <= '0;
                        eol_q   <= ONE_COL;
                        last_q  <= ONE_COL && ONE_ROW;
                        valid_q <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (valid_q && ob.out_ready) begin
                        if (last_q) begin
                            valid_q <= 1'b0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else if (eol_q) begin
                            // Row wrap: x restarts from the latched origin.
                            re_q   <= re0_q;
                            im_q   <= im_q - step_q;
                            px_q   <= '0;
                            py_q   <= py_d;
                            eol_q  <= ONE_COL;
                            last_q <= ONE_COL && (py_d == YL);
                        end else begin
                            re_q   <= re_q + step_q;
                            px_q   <= px_d;
                            eol_q  <= (px_d == XL);
                            last_q <= (px_d == XL) && (py_q == YL);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ob.out_valid = valid_q;
    assign ob.out_re    = re_q;
    assign ob.out_im    = im_q;
    assign ob.out_px    = px_q;
    assign ob.out_py    = py_q;
    assign ob.out_eol   = eol_q;
    assign ob.out_last  = last_q;
    assign busy         = busy_q;
    assign frame_done   = done_q;

endmodule

// File: doc/coord_scan_gen.md
COORD_SCAN_GEN -- requirements
Module: coord_scan_gen

Interface
REQ-001 SHALL have parameter Q, default 21, fraction bits of signed two's-complement fixed-point coordinates.
REQ-002 SHALL have parameter N, default 32, coordinate word width.
REQ-003 SHALL have parameter PXW, default 16, pixel-index width.
REQ-004 SHALL have parameter H_RES, default 640, pixels per row.
REQ-005 SHALL have parameter V_RES, default 480, rows per frame.
REQ-006 SHALL have parameter ZW, default 2, zoom_level width.
REQ-007 SHALL have parameter GRID_BASE, default 8, where the level-0 grid step is 2^-GRID_BASE.
REQ-008 SHALL have parameter ZOOM_STEP, default 1, extra halvings of the grid step per zoom level.
REQ-009 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-010 SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-011 SHALL have port start, input, 1 bit, frame start request.
REQ-012 SHALL have port abort, input, 1 bit, cancels the frame in progress.
REQ-013 SHALL have port start_re, input, N bits, real coordinate of pixel (0,0).
REQ-014 SHALL have port start_im, input, N bits, imaginary coordinate of pixel (0,0).
REQ-015 SHALL have port zoom_level, input, ZW bits, grid-step select.
REQ-016 SHALL have port out_ready, input, 1 bit, downstream accepts the current pixel.
REQ-017 SHALL have port out_valid, output, 1 bit, pixel word valid.
REQ-018 SHALL have ports out_re and out_im, output, N bits each, the pixel's complex coordinate.
REQ-019 SHALL have ports out_px and out_py, output, PXW bits each, pixel column and row.
REQ-020 SHALL have port out_eol, output, 1 bit, set when out_px = H_RES-1.
REQ-021 SHALL have port out_last, output, 1 bit, set on pixel (H_RES-1, V_RES-1).
REQ-022 SHALL have port busy, output, 1 bit, high in LOAD and RUN.
REQ-023 SHALL have port frame_done, output, 1 bit, one-cycle completion pulse.

Function
REQ-024 SHALL use FSM states IDLE, LOAD and RUN only.
REQ-025 In IDLE with start=1, SHALL latch start_re, start_im and zoom_level and go to LOAD; these inputs are ignored at all other times.
REQ-026 LOAD SHALL last exactly one cycle, load pixel (0,0) into the output registers, set out_valid=1 and go to RUN; first out_valid is therefore 2 edges after start is sampled.
REQ-027 SHALL use grid step g = 2^(Q - GRID_BASE - zoom_level*ZOOM_STEP) LSBs; Q >= GRID_BASE + (2^ZW-1)*ZOOM_STEP is a parameter legality rule enforced by an elaboration-time check.
REQ-028 SHALL output out_re = start_re + out_px*g and out_im = start_im - out_py*g, both modulo 2^N with no saturation.
REQ-029 SHALL form coordinates by incremental add/subtract of g, not by a multiplier.
REQ-030 A transfer SHALL occur on an edge with out_valid=1 and out_ready=1.
REQ-031 While out_valid=1 and out_ready=0, all out_* SHALL hold stable.
REQ-032 On a non-last transfer, SHALL present the next raster pixel on the same edge with no bubble; x advances first, and after x=H_RES-1 it wraps to x=0, y+1, out_re=latched start_re.
REQ-033 On the transfer of the out_last pixel, SHALL clear out_valid, go to IDLE and pulse frame_done high for the following cycle.
REQ-034 A start sampled in the same cycle frame_done is high (state IDLE) SHALL be accepted.
REQ-035 start while busy=1 SHALL be ignored.
REQ-036 abort=1 in LOAD or RUN SHALL take priority over transfer and start, go to IDLE, and clear out_valid at the next edge with no frame_done pulse.
REQ-037 abort in IDLE SHALL have no effect.
REQ-038 H_RES=1 and/or V_RES=1 SHALL be legal; out_eol and out_last SHALL then assert accordingly on the first pixel.

Reset
REQ-039 rst_n=0 SHALL immediately force state IDLE and clear out_valid, busy, frame_done, out_eol, out_last, out_re, out_im, out_px, out_py and the latched parameters to 0, independent of clk.
REQ-040 After rst_n rises, the first start SHALL be honoured on the first clk edge; reset mid-frame SHALL discard the frame with no frame_done pulse.

Verification
REQ-041 Use Q=21, N=32, H_RES=4, V_RES=3, start_re=0xFFC00000, start_im=0x00200000, zoom 0, out_ready=1 -> 12 transfers, one per cycle; (1,0) out_re=0xFFC02000; (3,2) out_re=0xFFC06000, out_im=0x001FC000; out_last and out_eol on (3,2); frame_done one cycle later.
REQ-042 Repeat with zoom 3 -> g=0x400; (3,2) out_re=0xFFC00C00, out_im=0x001FF800.
REQ-043 Toggle out_ready randomly -> outputs stable while stalled; no pixel skipped or duplicated; count = 12.
REQ-044 start_re=0x7FFFF000, zoom 0 -> pixel (1,0) out_re=0x80001000 (wrap, no saturation).
REQ-045 abort during pixel 5 with start also high -> out_valid=0 and busy=0 next edge; no frame_done; the next start restarts at (0,0).
REQ-046 rst_n low mid-frame between clk edges -> outputs 0 immediately; start asserted during RUN is ignored and the frame completes unchanged.
